arc4_encrypt: RTL

- Encryption-side counterpart of the task3 ARC4 decryptor.
- Takes a 24-bit key and reads a length-prefixed plaintext message from a PT memory.
- Runs the ARC4 init, KSA and PRGA phases against an external 256x8 S memory, then writes the length-prefixed ciphertext to a CT memory.
- Its output CT image must decrypt correctly in task3 with the same key. It sits beside task3 as a test-vector generator.

---
 rtl/arc4_encrypt.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext from PT memory, runs init/KSA/PRGA
// against an external 256x8 S memory and writes the length-prefixed ciphertext to CT memory.
module arc4_encrypt #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_KSA_RD_I,
        S_KSA_RD_J,
        S_KSA_WR_I,
        S_KSA_WR_J,
        S_LEN_RD,
        S_LEN_WR,
        S_PRGA_RD_I,
        S_PRGA_RD_J,
        S_PRGA_WR_I,
        S_PRGA_WR_J,
        S_PRGA_RD_PAD,
        S_PRGA_WR_CT,
        S_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [8*KEY_BYTES-1:0] key_q;
    logic [KW-1:0]          kidx;
    logic [7:0]             i, j, k, len, si, sj, pt_q;
    logic [7:0]             key_bytes [KEY_BYTES];
    logic [7:0]             key_byte, i_inc, j_ksa_nxt, j_prga_nxt;
    logic                   idle_like;

    // Key byte 0 sits in the most significant byte of the key port.
    always_comb begin
        for (int b = 0; b < KEY_BYTES; b++) begin
            key_bytes[b] = key_q[8*(KEY_BYTES-1-b) +: 8];
        end
        key_byte   = key_bytes[kidx];
        i_inc      = i + 8'd1;
        j_ksa_nxt  = j + s_rddata + key_byte;
        j_prga_nxt = j + s_rddata;
        idle_like  = (state == S_IDLE) || (state == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath registers; the S/PT/CT memories are external and keep their contents across reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
            kidx  <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            len   <= '0;
            si    <= '0;
            sj    <= '0;
            pt_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (en) begin
                        key_q <= key;
                        kidx  <= '0;
                        i     <= '0;
                        j     <= '0;
                    end
                end
                S_INIT: i <= i_inc;
                S_KSA_RD_J: begin
                    si <= s_rddata;
                    j  <= j_ksa_nxt;
                end
                S_KSA_WR_J: begin
                    i <= i_inc;
                    if (kidx == KW'(KEY_BYTES - 1)) kidx <= '0;
                    else                            kidx <= kidx + 1'b1;
                    if (i == 8'hFF) j <= '0;
                end
                S_LEN_WR: begin
                    len <= pt_rddata;
                    k   <= 8'd1;
                end
                S_PRGA_RD_I: i <= i_inc;
                S_PRGA_RD_J: begin
                    si   <= s_rddata;
                    j    <= j_prga_nxt;
                    pt_q <= pt_rddata;
                end
                S_PRGA_WR_I:  sj <= s_rddata;
                S_PRGA_WR_CT: k  <= k + 8'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: state_nxt = en ? S_INIT : S_IDLE;
            S_INIT:         if (i == 8'hFF) state_nxt = S_KSA_RD_I;
            S_KSA_RD_I:     state_nxt = S_KSA_RD_J;
            S_KSA_RD_J:     state_nxt = S_KSA_WR_I;
            S_KSA_WR_I:     state_nxt = S_KSA_WR_J;
            S_KSA_WR_J:     state_nxt = (i == 8'hFF) ? S_LEN_RD : S_KSA_RD_I;
            S_LEN_RD:       state_nxt = S_LEN_WR;
            S_LEN_WR:       state_nxt = (pt_rddata == 8'd0) ? S_DONE : S_PRGA_RD_I;
            S_PRGA_RD_I:    state_nxt = S_PRGA_RD_J;
            S_PRGA_RD_J:    state_nxt = S_PRGA_WR_I;
            S_PRGA_WR_I:    state_nxt = S_PRGA_WR_J;
            S_PRGA_WR_J:    state_nxt = S_PRGA_RD_PAD;
            S_PRGA_RD_PAD:  state_nxt = S_PRGA_WR_CT;
            S_PRGA_WR_CT:   state_nxt = (k == len) ? S_DONE : S_PRGA_RD_I;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        rdy       = idle_like;
        s_addr    = '0;
        s_wrdata  = '0;
        s_wren    = 1'b0;
        pt_addr   = '0;
        ct_addr   = '0;
        ct_wrdata = '0;
        ct_wren   = 1'b0;
        unique case (state)
            S_INIT: begin
                s_addr   = i;
                s_wrdata = i;
                s_wren   = 1'b1;
            end
            S_KSA_RD_I: s_addr = i;
            S_KSA_RD_J: s_addr = j_ksa_nxt;
            S_KSA_WR_I, S_PRGA_WR_I: begin
                s_addr   = i;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
            end
            S_KSA_WR_J, S_PRGA_WR_J: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
            end
            S_LEN_WR: begin
                ct_wrdata = pt_rddata;
                ct_wren   = 1'b1;
            end
            S_PRGA_RD_I: begin
                s_addr  = i_inc;
                pt_addr = k;
            end
            S_PRGA_RD_J:   s_addr = j_prga_nxt;
            // Post-swap S[i]=sj and S[j]=si, so the pad index sum is unchanged.
            S_PRGA_RD_PAD: s_addr = si + sj;
            S_PRGA_WR_CT: begin
                ct_addr   = k;
                ct_wrdata = pt_q ^ s_rddata;
                ct_wren   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
